multdiv_ctrl: RTL

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl_if.sv | 36 +++
 rtl/multdiv_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl_if.sv
// Bundle of decode-side and mult/div-unit-side signals for multdiv_ctrl.
// slave  : controller view (consumes decode and unit results, produces stall/issue/HI/LO/read data).
// master : environment view (drives decode and unit results, observes controller outputs).
interface multdiv_ctrl_if;
  // decode stage
  logic        id_valid;
  logic [4:0]  id_op;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic        stall;
  // mult/div unit
  logic [4:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_multwrite;
  logic        md_divwrite;
  // architectural state / read port / error pulses
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        dz_err;
  logic        wd_err;

  modport slave (
    input  id_valid, id_op, id_a, id_b, md_hi, md_lo, md_multwrite, md_divwrite,
    output stall, md_op, md_a, md_b, hi, lo, rd_data, rd_valid, dz_err, wd_err
  );

  modport master (
    output id_valid, id_op, id_a, id_b, md_hi, md_lo, md_multwrite, md_divwrite,
    input  stall, md_op, md_a, md_b, hi, lo, rd_data, rd_valid, dz_err, wd_err
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// HI/LO controller sequencing a multi-cycle mult/div unit: issue, wait for result pulse, watchdog abort.
// Latency: md_op one cycle after acceptance; HI/LO update on the edge sampling the matching result pulse.
// Backpressure: stall is high whenever not IDLE; decode ops presented while stalled are ignored.
// Ports: clk, rst (async active-low), bus (multdiv_ctrl_if.slave: decode, unit, HI/LO, read, errors).
module multdiv_ctrl #(
  parameter int WD_LIMIT = 40
) (
  input  logic           clk,
  input  logic           rst,
  multdiv_ctrl_if.slave  bus
);

  localparam logic [4:0] OP_MULT  = 5'b01101;
  localparam logic [4:0] OP_MULTU = 5'b01110;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_MFHI  = 5'b10001;
  localparam logic [4:0] OP_MFLO  = 5'b10010;
  localparam logic [4:0] OP_MTHI  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10100;

  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [5:0] WD_LAST = 6'(WD_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_op;
  logic        r_is_div;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_wd;
  logic        r_dz_err;
  logic        r_wd_err;

  logic w_idle_vld;
  logic w_is_mul;
  logic w_is_div;
  logic w_div_zero;
  logic w_start;
  logic w_done;
  logic w_expire;

  assign w_idle_vld = (r_state == S_IDLE) && bus.id_valid;
  assign w_is_mul   = (bus.id_op == OP_MULT) || (bus.id_op == OP_MULTU);
  assign w_is_div   = (bus.id_op == OP_DIV)  || (bus.id_op == OP_DIVU);
  assign w_div_zero = w_idle_vld && w_is_div && (bus.id_b == 32'd0);
  assign w_start    = w_idle_vld && (w_is_mul || (w_is_div && (bus.id_b != 32'd0)));
  // Only the pulse matching the issued op kind completes; the other is ignored.
  assign w_done     = (r_state == S_WAIT) && (r_is_div ? bus.md_divwrite : bus.md_multwrite);
  // A completion on the expiry edge wins over the watchdog.
  assign w_expire   = (r_state == S_WAIT) && !w_done && (r_wd == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done || w_expire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= 5'd0;
      r_is_div <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_wd     <= 6'd0;
      r_dz_err <= 1'b0;
      r_wd_err <= 1'b0;
    end else begin
      r_dz_err <= w_div_zero;
      r_wd_err <= w_expire;

      if (w_start) begin
        r_op     <= bus.id_op;
        r_is_div <= w_is_div;
        r_a      <= bus.id_a;
        r_b      <= bus.id_b;
      end

      if (r_state == S_ISSUE) begin
        r_wd <= 6'd0;
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + 6'd1;
      end

      // HI/LO pass through untouched; sign handling lives in the unit.
      if (w_done) begin
        r_hi <= bus.md_hi;
        r_lo <= bus.md_lo;
      end else if (w_idle_vld && (bus.id_op == OP_MTHI)) begin
        r_hi <= bus.id_a;
      end else if (w_idle_vld && (bus.id_op == OP_MTLO)) begin
        r_lo <= bus.id_a;
      end
    end
  end

  assign bus.stall    = (r_state != S_IDLE);
  assign bus.md_op    = (r_state == S_ISSUE) ? r_op : 5'd0;
  assign bus.md_a     = r_a;
  assign bus.md_b     = r_b;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.dz_err   = r_dz_err;
  assign bus.wd_err   = r_wd_err;
  assign bus.rd_valid = w_idle_vld && ((bus.id_op == OP_MFHI) || (bus.id_op == OP_MFLO));
  assign bus.rd_data  = !bus.rd_valid          ? 32'd0 :
                        (bus.id_op == OP_MFHI) ? r_hi  : r_lo;

endmodule
